neosd_sdclk_gen: RTL

NEOSD_SDCLK_GEN -- requirements
Module: neosd_sdclk_gen

---
 rtl/neosd_sdclk_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/neosd_sdclk_gen.sv
// SD bus clock generator: toggles sd_clk_o on prescaler ticks,
// runs for a fixed number of SD clock cycles or free-runs, and
// stops in an orderly way so the clock always ends low.
// Ports:
//   clk_i, rstn_i  system clock, async active-low reset
//   clk_en_i       prescaler tick strobes, bit k = divider k
//   sel_i          divider select, latched at start
//   start_i        start pulse (ignored while busy)
//   count_i        number of SD clock cycles, 0 = free-run
//   stop_i         orderly stop request
//   presc_en_o     prescaler enable (high while busy)
//   sd_clk_o       SD clock, idles low
//   rise_o/fall_o  one-cycle strobes with each SD clock edge
//   busy_o         high while not idle
//   done_o         one-cycle pulse on return to idle
module neosd_sdclk_gen #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [7:0]       clk_en_i,
   input  logic [2:0]       sel_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic             stop_i,
   output logic             presc_en_o,
   output logic             sd_clk_o,
   output logic             rise_o,
   output logic             fall_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_n;
   logic [2:0]       sel_q;
   logic [2:0]       sel_n;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W-1:0] rem_n;
   logic             clk_n;
   logic             rise_n;
   logic             fall_n;
   logic             done_n;
   logic             tick;
   logic             last;

   assign tick = clk_en_i[sel_q];
   // final falling edge of a counted run
   assign last = (rem_q == CNT_W'(1));

   // state and output registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_IDLE;
         sel_q      <= '0;
         rem_q      <= '0;
         sd_clk_o   <= 1'b0;
         rise_o     <= 1'b0;
         fall_o     <= 1'b0;
         done_o     <= 1'b0;
         busy_o     <= 1'b0;
         presc_en_o <= 1'b0;
      end else begin
         state_q    <= state_n;
         sel_q      <= sel_n;
         rem_q      <= rem_n;
         sd_clk_o   <= clk_n;
         rise_o     <= rise_n;
         fall_o     <= fall_n;
         done_o     <= done_n;
         busy_o     <= (state_n != S_IDLE);
         presc_en_o <= (state_n != S_IDLE);
      end
   end

   // next state
   always_comb begin
      state_n = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) state_n = S_RUN;
         end
         S_RUN: begin
            if (stop_i) begin
               // low: stop at once; high: finish the high phase
               if (!sd_clk_o || tick) state_n = S_IDLE;
               else                   state_n = S_STOP;
            end else if (tick && sd_clk_o && last) begin
               state_n = S_IDLE;
            end
         end
         S_STOP: begin
            if (tick) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // next values of the registered outputs and datapath
   always_comb begin
      clk_n  = sd_clk_o;
      rise_n = 1'b0;
      fall_n = 1'b0;
      rem_n  = rem_q;
      sel_n  = sel_q;
      done_n = (state_q != S_IDLE) && (state_n == S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               sel_n = sel_i;
               rem_n = count_i;
            end
         end
         S_RUN: begin
            if (tick) begin
               if (sd_clk_o) begin
                  clk_n  = 1'b0;
                  fall_n = 1'b1;
                  // zero means free-run, never wraps
                  if (rem_q != '0) rem_n = rem_q - CNT_W'(1);
               end else if (!stop_i) begin
                  clk_n  = 1'b1;
                  rise_n = 1'b1;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               clk_n  = 1'b0;
               fall_n = 1'b1;
            end
         end
         default: clk_n = 1'b0;
      endcase
   end

endmodule
